// File: rtl/riscv_uart_rx_if.sv
// Byte-side port of the UART receiver: received byte with valid/ready
// handshake, sticky error flags with their clear strobe, and a busy flag.
// Handshake: the receiver raises dOutValid while dOut holds an unconsumed
// byte and keeps dOut stable until a transfer; a transfer occurs on any
// clock edge where dOutValid && dOutReady, and the consumer may hold
// dOutReady high or low at will.
interface riscv_uart_rx_if;
  logic [7:0] dOut;
  logic       dOutValid;
  logic       dOutReady;
  logic       frameErr;
  logic       overrun;
  logic       clrErr;
  logic       busy;

  // Receiver side
  modport master (
    output dOut, dOutValid, frameErr, overrun, busy,
    input  dOutReady, clrErr
  );

  // Consumer side (bus glue / CPU I/O register block)
  modport slave (
    input  dOut, dOutValid, frameErr, overrun, busy,
    output dOutReady, clrErr
  );
endinterface

// File: rtl/riscv_uart_rx.sv
// 8N1 UART receiver. The rx line is synchronised, then an FSM times each
// bit from the middle of the start bit, assembles the byte LSB-first and
// hands it over through a one-entry holding register with valid/ready.
// Sticky frame-error and overrun flags are kept for software polling.
module riscv_uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  riscv_uart_rx_if.master        bus,
  output logic [2:0]             state_dbg
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES + 1);

  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  generate
    if (BIT_CYCLES < 4) begin : g_bad_cfg
      $error("riscv_uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    fill_q, fill_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic rxs;
  logic byte_done;
  logic stop_bad;
  logic xfer;
  logic overrun_set;

  assign rxs  = sync2_q;
  assign xfer = dout_valid_q && bus.dOutReady;

  // Synchroniser path plus a fill marker: the sync flops reset to 1, so
  // WAIT_HIGH only trusts rxs once two real rx samples have passed through.
  // Otherwise a line held low across reset would look briefly idle.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
  end

  // Receive FSM: bit timing, sampling and byte assembly
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (fill_q[1] && rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_WAIT_HIGH;
      end
    endcase
  end

  // Holding register: a completed byte loads only if the slot is free or
  // being emptied this cycle; otherwise it is dropped and overrun raised.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_set  = 1'b0;
    if (xfer) begin
      dout_valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!dout_valid_q || xfer) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end
  end

  // Sticky flags: clear first so that a same-cycle event still sets them
  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (bus.clrErr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (stop_bad) begin
      frame_err_d = 1'b1;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      fill_q       <= 2'b00;
      state_q      <= S_WAIT_HIGH;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      fill_q       <= fill_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dOut      = dout_q;
  assign bus.dOutValid = dout_valid_q;
  assign bus.frameErr  = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign state_dbg     = state_q;

endmodule
